// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target receiver.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_BYTE_W = 8;

  localparam logic I2C_RW_READ = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE,
    ST_WRITE_ACK,
    ST_READ,
    ST_READ_ACK,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Bus input conditioning: 2-flop synchronizers on scl/sda plus one history
// flop each. Edge and START/STOP conditions are decoded from the synchronized
// values only.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_d;
  logic       sda_d;
  logic       scl_s;

  // Synchronize and keep one cycle of history; reset to the idle-high bus level
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda_in};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C target receiver: address match/ACK and write-byte deserialization onto
// a strobe interface. Drives the bus only through an open-drain pull-low
// enable (sda_oe). Optional read path enabled by I2C_SLAVE_READ_EN.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] ADDR = 7'h50
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic [I2C_BYTE_W-1:0] data_out,
  output logic                  data_valid,
  output logic                  addr_hit,
  output logic                  busy
`ifdef I2C_SLAVE_READ_EN
  ,
  input  logic [I2C_BYTE_W-1:0] tx_data,
  output logic                  tx_req
`endif
);

  logic                  scl_rise;
  logic                  scl_fall;
  logic                  start_det;
  logic                  stop_det;
  logic                  sda_s;

  state_t                state;
  logic [3:0]            bit_cnt;
  logic [I2C_BYTE_W-2:0] shreg;
  logic [I2C_BYTE_W-1:0] rx_byte;
`ifdef I2C_SLAVE_READ_EN
  logic                  rw_q;
  logic [I2C_BYTE_W-2:0] tx_shreg;
`endif

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  // Byte as it stands once the bit currently on the bus is shifted in
  assign rx_byte = {shreg, sda_s};

  // Protocol FSM with shifter, bit counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      sda_oe     <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      addr_hit   <= 1'b0;
      busy       <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
      rw_q       <= 1'b0;
      tx_shreg   <= '0;
      tx_req     <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
      tx_req     <= 1'b0;
`endif
      if (stop_det) begin
        state    <= ST_IDLE;
        sda_oe   <= 1'b0;
        addr_hit <= 1'b0;
        busy     <= 1'b0;
      end else if (start_det) begin
        state    <= ST_ADDR;
        bit_cnt  <= '0;
        sda_oe   <= 1'b0;
        addr_hit <= 1'b0;
        busy     <= 1'b1;
      end else begin
        case (state)
          ST_ADDR: if (scl_rise) begin
            shreg   <= rx_byte[I2C_BYTE_W-2:0];
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (rx_byte[I2C_BYTE_W-1:1] != ADDR) begin
                state <= ST_IGNORE;
              end else begin
`ifdef I2C_SLAVE_READ_EN
                rw_q  <= rx_byte[0];
                state <= ST_ADDR_ACK;
`else
                state <= (rx_byte[0] == I2C_RW_READ) ? ST_IGNORE : ST_ADDR_ACK;
`endif
              end
            end
          end
          // sda_oe doubles as the ACK phase flag: low on entry, set on the first fall
          ST_ADDR_ACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe   <= 1'b1;
              addr_hit <= 1'b1;
            end else begin
              bit_cnt <= '0;
`ifdef I2C_SLAVE_READ_EN
              if (rw_q == I2C_RW_READ) begin
                state    <= ST_READ;
                tx_shreg <= tx_data[I2C_BYTE_W-2:0];
                sda_oe   <= ~tx_data[I2C_BYTE_W-1];
                tx_req   <= 1'b1;
              end else begin
                state  <= ST_WRITE;
                sda_oe <= 1'b0;
              end
`else
              state  <= ST_WRITE;
              sda_oe <= 1'b0;
`endif
            end
          end
          ST_WRITE: if (scl_rise) begin
            shreg   <= rx_byte[I2C_BYTE_W-2:0];
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              data_out   <= rx_byte;
              data_valid <= 1'b1;
              state      <= ST_WRITE_ACK;
            end
          end
          ST_WRITE_ACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= ST_WRITE;
            end
          end
`ifdef I2C_SLAVE_READ_EN
          ST_READ: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                state  <= ST_READ_ACK;
              end else begin
                sda_oe   <= ~tx_shreg[I2C_BYTE_W-2];
                tx_shreg <= {tx_shreg[I2C_BYTE_W-3:0], 1'b0};
              end
            end
          end
          // bit_cnt==9 marks a controller ACK seen, so the next fall reloads
          ST_READ_ACK: begin
            if (scl_rise) begin
              if (sda_s) begin
                state <= ST_IGNORE;
              end else begin
                bit_cnt <= 4'd9;
              end
            end else if (scl_fall && bit_cnt == 4'd9) begin
              state    <= ST_READ;
              bit_cnt  <= '0;
              tx_shreg <= tx_data[I2C_BYTE_W-2:0];
              sda_oe   <= ~tx_data[I2C_BYTE_W-1];
              tx_req   <= 1'b1;
            end
          end
`endif
          ST_IDLE, ST_IGNORE: begin
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
